// File: rtl/halting_tag_array_pkg.sv
// Shared constants, FSM state type and tag-splitting helper for the
// way-halting tag store.
package halting_tag_array_pkg;

  localparam int DEF_SETS   = 16;
  localparam int DEF_WAYS   = 4;
  localparam int DEF_HALT_W = 4;
  localparam int DEF_MAIN_W = 20;

  // Widest tag the split helper handles; HALT_W+MAIN_W must not exceed it.
  localparam int TAG_MAX_W  = 64;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    FIELD_HALT = 1'b0,
    FIELD_MAIN = 1'b1
  } tag_field_e;

  // Splits a zero-extended tag into its halt field (low halt_w bits) or its
  // main field (everything above). Callers truncate to the real field width.
  function automatic logic [TAG_MAX_W-1:0] split_tag(
    input logic [TAG_MAX_W-1:0] tag,
    input int unsigned          halt_w,
    input tag_field_e           field
  );
    logic [TAG_MAX_W-1:0] halt_mask;
    halt_mask = (TAG_MAX_W'(1) << halt_w) - TAG_MAX_W'(1);
    if (field == FIELD_MAIN) begin
      return tag >> halt_w;
    end
    return tag & halt_mask;
  endfunction

endpackage

// File: rtl/halting_tag_array_tag_way_entry.sv
// One tag-store entry: valid/halt/main storage plus its own halt and main
// comparators. The select inputs gate each comparator so only the addressed
// row (and, for main, only halt-passing ways) produces a match.
module tag_way_entry #(
  parameter int HALT_W = 4,
  parameter int MAIN_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              clr,
  input  logic [HALT_W-1:0] wr_halt,
  input  logic [MAIN_W-1:0] wr_main,
  input  logic              halt_sel,
  input  logic [HALT_W-1:0] halt_key,
  input  logic              main_sel,
  input  logic [MAIN_W-1:0] main_key,
  output logic              valid_o,
  output logic              halt_hit_o,
  output logic              main_hit_o
);

  logic              valid_q, valid_d;
  logic [HALT_W-1:0] halt_q, halt_d;
  logic [MAIN_W-1:0] main_q, main_d;

  // Next-state: clear wins over write (they never coincide in practice).
  always_comb begin
    valid_d = valid_q;
    halt_d  = halt_q;
    main_d  = main_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (wr_en) begin
      valid_d = 1'b1;
      halt_d  = wr_halt;
      main_d  = wr_main;
    end
  end

  // Valid bit is the only resettable state in the entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag bits carry no reset; they are meaningless while valid is low.
  always_ff @(posedge clk) begin
    halt_q <= halt_d;
    main_q <= main_d;
  end

  assign valid_o    = valid_q;
  assign halt_hit_o = halt_sel & valid_q & (halt_q == halt_key);
  assign main_hit_o = main_sel & (main_q == main_key);

endmodule

// File: rtl/halting_tag_array.sv
// Set-associative tag store with way-halting lookup: a cheap halt-tag compare
// in the accept cycle filters which ways get the full main-tag compare one
// cycle later. Also handles fills, per-set round-robin victims and a
// set-by-set flush sequencer.
module halting_tag_array
  import halting_tag_array_pkg::*;
#(
  parameter  int SETS   = DEF_SETS,
  parameter  int WAYS   = DEF_WAYS,
  parameter  int HALT_W = DEF_HALT_W,
  parameter  int MAIN_W = DEF_MAIN_W,
  localparam int IDX_W  = $clog2(SETS),
  localparam int WAY_W  = $clog2(WAYS),
  localparam int TAG_W  = HALT_W + MAIN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lk_valid,
  output logic             lk_ready,
  input  logic [IDX_W-1:0] lk_index,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAY_W-1:0] rsp_way,
  output logic [WAYS-1:0]  rsp_onehot,
  output logic [WAYS-1:0]  rsp_halt_mask,
  output logic [WAY_W-1:0] rsp_victim,
  input  logic             fill_valid,
  input  logic [IDX_W-1:0] fill_index,
  input  logic [WAY_W-1:0] fill_way,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic             flush_req,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             flush_active;

  logic [WAY_W-1:0] ptr_q [SETS];
  logic [WAY_W-1:0] ptr_d [SETS];

  logic             s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic [MAIN_W-1:0] s1_main_q, s1_main_d;
  logic [WAYS-1:0]  s1_mask_q, s1_mask_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_hit_q, rsp_hit_d;
  logic [WAY_W-1:0] rsp_way_q, rsp_way_d;
  logic [WAYS-1:0]  rsp_onehot_q, rsp_onehot_d;
  logic [WAYS-1:0]  rsp_halt_mask_q, rsp_halt_mask_d;
  logic [WAY_W-1:0] rsp_victim_q, rsp_victim_d;

  logic [HALT_W-1:0] lk_halt, fill_halt;
  logic [MAIN_W-1:0] lk_main, fill_main;
  logic              lk_fire, fill_we;

  logic [WAYS-1:0] ent_valid    [SETS];
  logic [WAYS-1:0] ent_halt_hit [SETS];
  logic [WAYS-1:0] ent_main_hit [SETS];
  logic [WAYS-1:0] halt_mask, main_match, s1_set_valid;

  logic             hit_found, inv_found;
  logic [WAY_W-1:0] victim_sel;

  assign lk_halt   = HALT_W'(split_tag(TAG_MAX_W'(lk_tag), HALT_W, FIELD_HALT));
  assign lk_main   = MAIN_W'(split_tag(TAG_MAX_W'(lk_tag), HALT_W, FIELD_MAIN));
  assign fill_halt = HALT_W'(split_tag(TAG_MAX_W'(fill_tag), HALT_W, FIELD_HALT));
  assign fill_main = MAIN_W'(split_tag(TAG_MAX_W'(fill_tag), HALT_W, FIELD_MAIN));

  // A flush request takes priority over a lookup presented in the same cycle.
  assign lk_ready = (state_q == ST_IDLE) & ~flush_req;
  assign lk_fire  = lk_valid & lk_ready;
  assign fill_we  = fill_valid & (state_q == ST_IDLE);
  assign busy     = (state_q == ST_FLUSH);

  // Entry array: one storage/compare cell per (set, way).
  for (genvar gi = 0; gi < SETS; gi++) begin : g_set
    for (genvar gj = 0; gj < WAYS; gj++) begin : g_way
      tag_way_entry #(
        .HALT_W (HALT_W),
        .MAIN_W (MAIN_W)
      ) u_entry (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (fill_we && (fill_index == IDX_W'(gi)) && (fill_way == WAY_W'(gj))),
        .clr        (flush_active && (flush_cnt_q == IDX_W'(gi))),
        .wr_halt    (fill_halt),
        .wr_main    (fill_main),
        .halt_sel   (lk_fire && (lk_index == IDX_W'(gi))),
        .halt_key   (lk_halt),
        .main_sel   (s1_valid_q && (s1_idx_q == IDX_W'(gi)) && s1_mask_q[gj]),
        .main_key   (s1_main_q),
        .valid_o    (ent_valid[gi][gj]),
        .halt_hit_o (ent_halt_hit[gi][gj]),
        .main_hit_o (ent_main_hit[gi][gj])
      );
    end
  end

  // Collapse per-set compare results; only the selected row can be nonzero.
  always_comb begin
    halt_mask  = '0;
    main_match = '0;
    for (int s = 0; s < SETS; s++) begin
      halt_mask  = halt_mask  | ent_halt_hit[s];
      main_match = main_match | ent_main_hit[s];
    end
  end

  assign s1_set_valid = ent_valid[s1_idx_q];

  // Flush sequencer: walk every set once, one set per cycle.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    flush_active = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end
      end
      ST_FLUSH: begin
        flush_active = 1'b1;
        flush_cnt_d  = flush_cnt_q + IDX_W'(1);
        if (flush_cnt_q == IDX_W'(SETS - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Round-robin pointer advances on every accepted fill of its set.
  always_comb begin
    ptr_d = ptr_q;
    if (fill_we) begin
      ptr_d[fill_index] = ptr_q[fill_index] + WAY_W'(1);
    end
  end

  // Accept stage: capture halt compare results and what the main compare needs.
  always_comb begin
    s1_valid_d = lk_fire;
    s1_idx_d   = lk_index;
    s1_main_d  = lk_main;
    s1_mask_d  = halt_mask;
  end

  // Compare stage: hit/way priority encode and victim choice.
  always_comb begin
    rsp_valid_d     = s1_valid_q;
    rsp_hit_d       = 1'b0;
    rsp_way_d       = '0;
    rsp_onehot_d    = '0;
    rsp_halt_mask_d = '0;
    rsp_victim_d    = '0;
    hit_found       = 1'b0;
    inv_found       = 1'b0;
    victim_sel      = ptr_q[s1_idx_q];
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_found && !s1_set_valid[w]) begin
        victim_sel = WAY_W'(w);
        inv_found  = 1'b1;
      end
    end
    if (s1_valid_q) begin
      rsp_hit_d       = |main_match;
      rsp_onehot_d    = main_match;
      rsp_halt_mask_d = s1_mask_q;
      rsp_victim_d    = victim_sel;
      for (int w = 0; w < WAYS; w++) begin
        if (!hit_found && main_match[w]) begin
          rsp_way_d = WAY_W'(w);
          hit_found = 1'b1;
        end
      end
    end
  end

  // Control, pointer and pipeline registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      flush_cnt_q     <= '0;
      s1_valid_q      <= 1'b0;
      s1_idx_q        <= '0;
      s1_main_q       <= '0;
      s1_mask_q       <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_hit_q       <= 1'b0;
      rsp_way_q       <= '0;
      rsp_onehot_q    <= '0;
      rsp_halt_mask_q <= '0;
      rsp_victim_q    <= '0;
      for (int s = 0; s < SETS; s++) begin
        ptr_q[s] <= '0;
      end
    end else begin
      state_q         <= state_d;
      flush_cnt_q     <= flush_cnt_d;
      s1_valid_q      <= s1_valid_d;
      s1_idx_q        <= s1_idx_d;
      s1_main_q       <= s1_main_d;
      s1_mask_q       <= s1_mask_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_hit_q       <= rsp_hit_d;
      rsp_way_q       <= rsp_way_d;
      rsp_onehot_q    <= rsp_onehot_d;
      rsp_halt_mask_q <= rsp_halt_mask_d;
      rsp_victim_q    <= rsp_victim_d;
      for (int s = 0; s < SETS; s++) begin
        ptr_q[s] <= ptr_d[s];
      end
    end
  end

  assign rsp_valid     = rsp_valid_q;
  assign rsp_hit       = rsp_hit_q;
  assign rsp_way       = rsp_way_q;
  assign rsp_onehot    = rsp_onehot_q;
  assign rsp_halt_mask = rsp_halt_mask_q;
  assign rsp_victim    = rsp_victim_q;

endmodule

// File: tb/tb_halting_tag_array.sv
// Directed bench for halting_tag_array with hand-computed expectations.
module tb_halting_tag_array;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        lk_valid = 1'b0;
  logic        lk_ready;
  logic [3:0]  lk_index = '0;
  logic [23:0] lk_tag = '0;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [1:0]  rsp_way;
  logic [3:0]  rsp_onehot;
  logic [3:0]  rsp_halt_mask;
  logic [1:0]  rsp_victim;
  logic        fill_valid = 1'b0;
  logic [3:0]  fill_index = '0;
  logic [1:0]  fill_way = '0;
  logic [23:0] fill_tag = '0;
  logic        flush_req = 1'b0;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  halting_tag_array dut (
    .clk           (clk),
    .reset         (reset),
    .lk_valid      (lk_valid),
    .lk_ready      (lk_ready),
    .lk_index      (lk_index),
    .lk_tag        (lk_tag),
    .rsp_valid     (rsp_valid),
    .rsp_hit       (rsp_hit),
    .rsp_way       (rsp_way),
    .rsp_onehot    (rsp_onehot),
    .rsp_halt_mask (rsp_halt_mask),
    .rsp_victim    (rsp_victim),
    .fill_valid    (fill_valid),
    .fill_index    (fill_index),
    .fill_way      (fill_way),
    .fill_tag      (fill_tag),
    .flush_req     (flush_req),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic check_rsp(input string name, input logic exp_hit, input logic [1:0] exp_way,
                           input logic [3:0] exp_oh, input logic [3:0] exp_mask,
                           input logic [1:0] exp_vic);
    check({name, ".valid"}, rsp_valid, 1);
    check({name, ".hit"}, rsp_hit, exp_hit);
    check({name, ".way"}, rsp_way, exp_way);
    check({name, ".onehot"}, rsp_onehot, exp_oh);
    check({name, ".halt_mask"}, rsp_halt_mask, exp_mask);
    check({name, ".victim"}, rsp_victim, exp_vic);
    $display("lookup %s hit=%0d way=%0d onehot=%b halt=%b victim=%0d",
             name, rsp_hit, rsp_way, rsp_onehot, rsp_halt_mask, rsp_victim);
  endtask

  // Single lookup: present at a negedge, response expected two edges later.
  task automatic lookup(input string name, input logic [3:0] idx, input logic [23:0] tag,
                        input logic exp_hit, input logic [1:0] exp_way, input logic [3:0] exp_oh,
                        input logic [3:0] exp_mask, input logic [1:0] exp_vic);
    @(negedge clk);
    lk_valid = 1'b1;
    lk_index = idx;
    lk_tag   = tag;
    #1;
    check({name, ".ready"}, lk_ready, 1);
    @(negedge clk);
    lk_valid = 1'b0;
    check({name, ".early"}, rsp_valid, 0);
    @(negedge clk);
    check_rsp(name, exp_hit, exp_way, exp_oh, exp_mask, exp_vic);
  endtask

  task automatic fill(input logic [3:0] idx, input logic [1:0] way, input logic [23:0] tag);
    @(negedge clk);
    fill_valid = 1'b1;
    fill_index = idx;
    fill_way   = way;
    fill_tag   = tag;
    @(negedge clk);
    fill_valid = 1'b0;
    $display("fill set=%0d way=%0d tag=%06h", idx, way, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int ready_seen;
    int rsp_seen;

    // 1. reset state and a miss on an empty array
    repeat (3) @(negedge clk);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.rsp_hit", rsp_hit, 0);
    check("rst.busy", busy, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst.lk_ready", lk_ready, 1);
    lookup("t1_empty", 4'd3, 24'hABCDE5, 0, 2'd0, 4'b0000, 4'b0000, 2'd0);

    // 2. single fill then hit
    fill(4'd3, 2'd2, 24'h123456);
    lookup("t2_hit", 4'd3, 24'h123456, 1, 2'd2, 4'b0100, 4'b0100, 2'd0);

    // 3. second way with same halt nibble
    fill(4'd3, 2'd0, 24'h999996);
    lookup("t3_a", 4'd3, 24'h123456, 1, 2'd2, 4'b0100, 4'b0101, 2'd1);
    lookup("t3_b", 4'd3, 24'h999996, 1, 2'd0, 4'b0001, 4'b0101, 2'd1);
    lookup("t3_c", 4'd3, 24'h000006, 0, 2'd0, 4'b0000, 4'b0101, 2'd1);

    // 4. round-robin pointer wrap on a full set
    for (int w = 0; w < 4; w++) fill(4'd5, 2'(w), 24'h500000 | 24'(w));
    lookup("t4_wrap", 4'd5, 24'hFFFFFF, 0, 2'd0, 4'b0000, 4'b0000, 2'd0);
    fill(4'd5, 2'd0, 24'h500000);
    lookup("t4_next", 4'd5, 24'hFFFFFF, 0, 2'd0, 4'b0000, 4'b0000, 2'd1);

    // 5a. flush; simultaneous lookup must lose, fill during flush dropped
    @(negedge clk);
    flush_req = 1'b1;
    lk_valid  = 1'b1;
    lk_index  = 4'd3;
    lk_tag    = 24'h123456;
    #1;
    check("t5.ready_vs_flush", lk_ready, 0);
    @(negedge clk);
    flush_req = 1'b0;
    lk_valid  = 1'b0;
    busy_cnt = 0;
    ready_seen = 0;
    rsp_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (!busy) break;
      busy_cnt++;
      if (lk_ready) ready_seen = 1;
      if (rsp_valid) rsp_seen = 1;
      if (busy_cnt == 3) begin
        fill_valid = 1'b1;
        fill_index = 4'd7;
        fill_way   = 2'd0;
        fill_tag   = 24'h777777;
      end else begin
        fill_valid = 1'b0;
      end
      @(negedge clk);
    end
    fill_valid = 1'b0;
    check("t5.busy_cycles", busy_cnt, 16);
    check("t5.ready_in_flush", ready_seen, 0);
    check("t5.rsp_in_flush", rsp_seen, 0);
    $display("flush busy_cycles=%0d", busy_cnt);
    lookup("t5_after", 4'd3, 24'h123456, 0, 2'd0, 4'b0000, 4'b0000, 2'd0);
    lookup("t5_dropfill", 4'd7, 24'h777777, 0, 2'd0, 4'b0000, 4'b0000, 2'd0);

    // 5b. reset on flush cycle 7 aborts flush and clears all valids/pointers
    fill(4'd12, 2'd1, 24'hC0FFEE);
    fill(4'd3, 2'd2, 24'h123456);
    fill(4'd5, 2'd0, 24'h500000);
    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (!busy) break;
      busy_cnt++;
      if (busy_cnt == 7) reset = 1'b0;
      @(negedge clk);
    end
    check("t5r.busy_cycles", busy_cnt, 7);
    check("t5r.busy_after", busy, 0);
    check("t5r.rsp_valid", rsp_valid, 0);
    $display("flush_reset busy_cycles=%0d", busy_cnt);
    reset = 1'b1;
    lookup("t5r_set12", 4'd12, 24'hC0FFEE, 0, 2'd0, 4'b0000, 4'b0000, 2'd0);
    lookup("t5r_set3", 4'd3, 24'h123456, 0, 2'd0, 4'b0000, 4'b0000, 2'd0);
    // set5 pointer was 2 before reset; four fills return it to its reset value 0
    for (int w = 0; w < 4; w++) fill(4'd5, 2'(w), 24'h500000 | 24'(w));
    lookup("t5r_ptr", 4'd5, 24'hFFFFFF, 0, 2'd0, 4'b0000, 4'b0000, 2'd0);

    // 6. fill colliding with lookup accept, then back-to-back lookup
    @(negedge clk);
    lk_valid   = 1'b1;
    lk_index   = 4'd3;
    lk_tag     = 24'h0000A1;
    fill_valid = 1'b1;
    fill_index = 4'd3;
    fill_way   = 2'd1;
    fill_tag   = 24'h0000A1;
    @(negedge clk);
    fill_valid = 1'b0;
    #1;
    check("t6.ready_b2b", lk_ready, 1);
    @(negedge clk);
    lk_valid = 1'b0;
    check_rsp("t6_same_cycle", 0, 2'd0, 4'b0000, 4'b0000, 2'd0);
    @(negedge clk);
    check_rsp("t6_next", 1, 2'd1, 4'b0010, 4'b0010, 2'd0);
    @(negedge clk);
    check("t6.single_pulse", rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/halting_tag_array.md
Name: halting_tag_array

Overview:
Parametrised set-associative tag store with way-halting lookup for the data cache. Each entry holds a valid bit, a HALT_W-bit halt tag (low tag bits) and a MAIN_W-bit main tag. A lookup first compares halt tags across all ways of the indexed set. It then compares main tags only on ways whose halt tag matched, which saves compare energy. The block also provides fill writes, per-set round-robin victim selection and a set-by-set flush sequencer. It sits between address decode and the cache data array and controller.

Parameters:
SETS, 16, number of sets (power of two, >=2)
WAYS, 4, associativity (power of two, >=2)
HALT_W, 4, halt-tag width, taken from tag[HALT_W-1:0]
MAIN_W, 20, main-tag width, taken from tag[HALT_W+MAIN_W-1:HALT_W]
IDX_W, clog2(SETS), index width (derived)
WAY_W, clog2(WAYS), way-number width (derived)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
lk_valid  in  1  lookup request
lk_ready  out  1  lookup accepted when lk_valid&lk_ready
lk_index  in  IDX_W  lookup set
lk_tag  in  HALT_W+MAIN_W  lookup tag
rsp_valid  out  1  response valid, one cycle
rsp_hit  out  1  hit
rsp_way  out  WAY_W  hitting way, lowest index on multi-hit
rsp_onehot  out  WAYS  one-hot hit vector, raw per-way main match
rsp_halt_mask  out  WAYS  ways that passed the halt compare
rsp_victim  out  WAY_W  suggested replacement way for the looked-up set
fill_valid  in  1  write entry
fill_index  in  IDX_W  fill set
fill_way  in  WAY_W  fill way
fill_tag  in  HALT_W+MAIN_W  fill tag
flush_req  in  1  invalidate-all request, one-cycle pulse
busy  out  1  flush in progress

Behaviour:
- Reset (reset==0 at clk edge):
  - All valid bits clear; all round-robin pointers become 0.
  - FSM goes to IDLE; pipeline valids clear.
  - All rsp_* outputs become 0; busy becomes 0.
  - Tag bits are not reset.
  - Reset mid-flush or mid-lookup aborts the operation; no rsp_valid is produced for in-flight lookups.
- FSM states:
  - IDLE to FLUSH on flush_req; the flush counter loads 0.
  - FLUSH clears the valid bits of set[counter] each cycle and increments the counter.
  - FLUSH returns to IDLE after set SETS-1 is cleared.
  - busy=1 exactly SETS cycles.
  - flush_req while in FLUSH is ignored.
- lk_ready = (state==IDLE) & ~flush_req. A flush request beats a simultaneous lookup.
- Lookup pipeline, latency 2:
  - Cycle A (accept): read the set's valid and halt tags; halt_mask[w] = valid[w] & (halt[w]==lk_tag[HALT_W-1:0]). Register halt_mask, index and main tag.
  - Cycle A+1: match[w] = halt_mask[w] & (main[w]==stored main tag). Main compare is evaluated only for ways in halt_mask.
  - Victim = lowest-index invalid way of the set, else the set's pointer. Register all results.
  - Cycle A+2: rsp_valid=1 with the registered results.
  - Throughput is one lookup per cycle.
  - rsp_way is 0 when rsp_hit=0.
- Array reads in every stage see contents before that cycle's write. A fill or flush clear in cycle N is visible to reads from cycle N+1.
- Lookups already in flight when FLUSH starts complete normally against the array contents at each stage.
- Fill:
  - fill_valid in IDLE writes valid=1, halt and main into [fill_index][fill_way].
  - The set's pointer advances to (pointer+1) mod WAYS, wrapping at WAYS-1.
  - fill_valid while busy is dropped.
  - Duplicate tags across ways are not checked.
- Flush does not change the pointers.

Decomposition:
- Package halting_tag_array_pkg: default parameter constants, FSM state enum (IDLE, FLUSH), and a function that splits a tag into its halt and main fields.
- One sub-module, tag_way_entry: storage for a single entry (valid, halt, main) with write enable, row select and synchronous clear, plus the halt and main comparators. It is instantiated SETS*WAYS times.

Test Plan:
1. Reset, then lookup index 3 tag 0xABCDE5 -> rsp_valid two cycles after accept; hit=0, halt_mask=0000, onehot=0000, victim=0.
2. Fill set3 way2 tag 0x123456, then lookup set3 0x123456 -> hit=1, way=2, onehot=0100, halt_mask=0100.
3. Additionally fill set3 way0 0x999996 (same halt nibble 6):
   - Lookup 0x123456 -> halt_mask=0101, way=2.
   - Lookup 0x999996 -> way=0.
   - Lookup 0x000006 -> halt_mask=0101, hit=0.
4. Fill set5 ways 0..3 in turn, then lookup set5 miss -> victim=0 (pointer wrapped after 4 fills). One more fill, then miss -> victim=1.
5. Flush pulse -> busy=1 for exactly 16 cycles and lk_ready=0. A fill during the flush is dropped. Afterwards, lookup of 0x123456 in set3 -> hit=0.
   - Repeat with reset asserted on flush cycle 7 -> busy=0 next cycle; all lookups miss.
6. Fill set3 way1 0x0000A1 in the same cycle as accepting lookup set3 0x0000A1 -> rsp_hit=0. Next lookup -> hit=1, way=1.
